// File: rtl/alu_rs_scheduler_pkg.sv
// Shared constants for the ALU reservation station and issue scheduler.
// Holds operand/tag/opcode widths and the idle (zero) encodings for each.
package alu_rs_scheduler_pkg;

    localparam int RS_OP_W   = 6;
    localparam int RS_TAG_W  = 4;
    localparam int RS_DATA_W = 32;

    localparam logic [RS_OP_W-1:0]   NOP          = '0;
    localparam logic [RS_TAG_W-1:0]  ZERO_TAG_ROB = '0;
    localparam logic [RS_DATA_W-1:0] ZERO_DATA    = '0;

endpackage

// File: rtl/alu_rs_scheduler_rs_prio_select.sv
// Lowest-index priority encoder: turns a request vector into the index of
// its lowest set bit plus a found flag.
// Ports: req (N requests) -> idx (W-bit index), found (any request set).
module rs_prio_select #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = i[W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs_scheduler.sv
// Reservation station for the ALU: accepts dispatched ops, wakes operands
// from the ALU/LSB broadcasts, issues the lowest ready entry each cycle.
// Ports: clk, rst (async high), rdy (global stall when low), in_clear (flush),
//   in_disp_* (dispatch bundle), in_{alu,lsb}_cdb_{tag,val} (broadcasts),
//   out_full (no free entry), out_* (registered issue bundle to the ALU).
module alu_rs_scheduler
    import alu_rs_scheduler_pkg::*;
#(
    parameter int RS_SIZE = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = RS_TAG_W,
    parameter int OP_W    = RS_OP_W,
    parameter int DATA_W  = RS_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              in_clear,
    input  logic              in_disp_valid,
    input  logic [OP_W-1:0]   in_disp_op,
    input  logic [DATA_W-1:0] in_disp_v1,
    input  logic [DATA_W-1:0] in_disp_v2,
    input  logic [TAG_W-1:0]  in_disp_q1,
    input  logic [TAG_W-1:0]  in_disp_q2,
    input  logic [DATA_W-1:0] in_disp_imm,
    input  logic [DATA_W-1:0] in_disp_pc,
    input  logic [TAG_W-1:0]  in_disp_tag,
    input  logic [TAG_W-1:0]  in_alu_cdb_tag,
    input  logic [DATA_W-1:0] in_alu_cdb_val,
    input  logic [TAG_W-1:0]  in_lsb_cdb_tag,
    input  logic [DATA_W-1:0] in_lsb_cdb_val,
    output logic              out_full,
    output logic [OP_W-1:0]   out_op,
    output logic [DATA_W-1:0] out_v1,
    output logic [DATA_W-1:0] out_v2,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_pc,
    output logic [TAG_W-1:0]  out_rob_tag
);

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] ready;
    logic [RS_SIZE-1:0] free;

    logic [OP_W-1:0]   ent_op  [RS_SIZE];
    logic [DATA_W-1:0] ent_v1  [RS_SIZE];
    logic [DATA_W-1:0] ent_v2  [RS_SIZE];
    logic [TAG_W-1:0]  ent_q1  [RS_SIZE];
    logic [TAG_W-1:0]  ent_q2  [RS_SIZE];
    logic [DATA_W-1:0] ent_imm [RS_SIZE];
    logic [DATA_W-1:0] ent_pc  [RS_SIZE];
    logic [TAG_W-1:0]  ent_tag [RS_SIZE];

    logic [IDX_W-1:0]  free_idx;
    logic              free_found;
    logic [IDX_W-1:0]  iss_idx;
    logic              iss_found;

    logic [DATA_W-1:0] disp_v1;
    logic [DATA_W-1:0] disp_v2;
    logic [TAG_W-1:0]  disp_q1;
    logic [TAG_W-1:0]  disp_q2;
    logic              do_disp;
    logic              live;

    assign live     = rdy && !in_clear;
    assign free     = ~busy;
    assign out_full = &busy;
    assign do_disp  = live && in_disp_valid && free_found;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = busy[i] && (ent_q1[i] == '0) && (ent_q2[i] == '0);
        end
    end

    rs_prio_select #(.N(RS_SIZE), .W(IDX_W)) u_free_sel (
        .req   (free),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_prio_select #(.N(RS_SIZE), .W(IDX_W)) u_issue_sel (
        .req   (ready),
        .idx   (iss_idx),
        .found (iss_found)
    );

    // Same-cycle broadcast bypass for dispatched operands; ALU CDB wins.
    always_comb begin
        disp_v1 = in_disp_v1;
        disp_q1 = in_disp_q1;
        disp_v2 = in_disp_v2;
        disp_q2 = in_disp_q2;
        if (in_disp_q1 != '0) begin
            if (in_disp_q1 == in_alu_cdb_tag) begin
                disp_v1 = in_alu_cdb_val;
                disp_q1 = '0;
            end else if (in_disp_q1 == in_lsb_cdb_tag) begin
                disp_v1 = in_lsb_cdb_val;
                disp_q1 = '0;
            end
        end
        if (in_disp_q2 != '0) begin
            if (in_disp_q2 == in_alu_cdb_tag) begin
                disp_v2 = in_alu_cdb_val;
                disp_q2 = '0;
            end else if (in_disp_q2 == in_lsb_cdb_tag) begin
                disp_v2 = in_lsb_cdb_val;
                disp_q2 = '0;
            end
        end
    end

    // Payload is qualified by busy, so it needs no reset.
    always_ff @(posedge clk) begin
        if (live) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && ent_q1[i] != '0) begin
                    if (ent_q1[i] == in_alu_cdb_tag) begin
                        ent_v1[i] <= in_alu_cdb_val;
                        ent_q1[i] <= '0;
                    end else if (ent_q1[i] == in_lsb_cdb_tag) begin
                        ent_v1[i] <= in_lsb_cdb_val;
                        ent_q1[i] <= '0;
                    end
                end
                if (busy[i] && ent_q2[i] != '0) begin
                    if (ent_q2[i] == in_alu_cdb_tag) begin
                        ent_v2[i] <= in_alu_cdb_val;
                        ent_q2[i] <= '0;
                    end else if (ent_q2[i] == in_lsb_cdb_tag) begin
                        ent_v2[i] <= in_lsb_cdb_val;
                        ent_q2[i] <= '0;
                    end
                end
            end
            // The free slot is never busy, so no wake-up touches it.
            if (do_disp) begin
                ent_op[free_idx]  <= in_disp_op;
                ent_v1[free_idx]  <= disp_v1;
                ent_q1[free_idx]  <= disp_q1;
                ent_v2[free_idx]  <= disp_v2;
                ent_q2[free_idx]  <= disp_q2;
                ent_imm[free_idx] <= in_disp_imm;
                ent_pc[free_idx]  <= in_disp_pc;
                ent_tag[free_idx] <= in_disp_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= '0;
            out_op      <= NOP;
            out_v1      <= ZERO_DATA;
            out_v2      <= ZERO_DATA;
            out_imm     <= ZERO_DATA;
            out_pc      <= ZERO_DATA;
            out_rob_tag <= ZERO_TAG_ROB;
        end else if (rdy) begin
            if (in_clear) begin
                busy   <= '0;
                out_op <= NOP;
            end else begin
                if (iss_found) begin
                    busy[iss_idx] <= 1'b0;
                    out_op        <= ent_op[iss_idx];
                    out_v1        <= ent_v1[iss_idx];
                    out_v2        <= ent_v2[iss_idx];
                    out_imm       <= ent_imm[iss_idx];
                    out_pc        <= ent_pc[iss_idx];
                    out_rob_tag   <= ent_tag[iss_idx];
                end else begin
                    out_op <= NOP;
                end
                // Free slot comes from pre-edge busy, never the issuing one.
                if (do_disp) begin
                    busy[free_idx] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench for alu_rs_scheduler with hand-computed expectations.
// Drives inputs 1ns after the rising edge and samples there too.
module tb_alu_rs_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        in_clear;
    logic        in_disp_valid;
    logic [5:0]  in_disp_op;
    logic [31:0] in_disp_v1;
    logic [31:0] in_disp_v2;
    logic [3:0]  in_disp_q1;
    logic [3:0]  in_disp_q2;
    logic [31:0] in_disp_imm;
    logic [31:0] in_disp_pc;
    logic [3:0]  in_disp_tag;
    logic [3:0]  in_alu_cdb_tag;
    logic [31:0] in_alu_cdb_val;
    logic [3:0]  in_lsb_cdb_tag;
    logic [31:0] in_lsb_cdb_val;
    logic        out_full;
    logic [5:0]  out_op;
    logic [31:0] out_v1;
    logic [31:0] out_v2;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic [3:0]  out_rob_tag;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_rs_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .in_clear       (in_clear),
        .in_disp_valid  (in_disp_valid),
        .in_disp_op     (in_disp_op),
        .in_disp_v1     (in_disp_v1),
        .in_disp_v2     (in_disp_v2),
        .in_disp_q1     (in_disp_q1),
        .in_disp_q2     (in_disp_q2),
        .in_disp_imm    (in_disp_imm),
        .in_disp_pc     (in_disp_pc),
        .in_disp_tag    (in_disp_tag),
        .in_alu_cdb_tag (in_alu_cdb_tag),
        .in_alu_cdb_val (in_alu_cdb_val),
        .in_lsb_cdb_tag (in_lsb_cdb_tag),
        .in_lsb_cdb_val (in_lsb_cdb_val),
        .out_full       (out_full),
        .out_op         (out_op),
        .out_v1         (out_v1),
        .out_v2         (out_v2),
        .out_imm        (out_imm),
        .out_pc         (out_pc),
        .out_rob_tag    (out_rob_tag)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_clear       = 1'b0;
        in_disp_valid  = 1'b0;
        in_disp_op     = '0;
        in_disp_v1     = '0;
        in_disp_v2     = '0;
        in_disp_q1     = '0;
        in_disp_q2     = '0;
        in_disp_imm    = '0;
        in_disp_pc     = '0;
        in_disp_tag    = '0;
        in_alu_cdb_tag = '0;
        in_alu_cdb_val = '0;
        in_lsb_cdb_tag = '0;
        in_lsb_cdb_val = '0;
    endtask

    task automatic disp(input logic [5:0] op, input logic [31:0] v1,
                        input logic [3:0] q1, input logic [31:0] v2,
                        input logic [3:0] q2, input logic [3:0] tag);
        in_disp_valid = 1'b1;
        in_disp_op    = op;
        in_disp_v1    = v1;
        in_disp_q1    = q1;
        in_disp_v2    = v2;
        in_disp_q2    = q2;
        in_disp_tag   = tag;
        in_disp_imm   = 32'h100 + 32'(op);
        in_disp_pc    = 32'h1000 + 32'(op) * 4;
    endtask

    task automatic nodisp();
        in_disp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        idle();
        repeat (2) tick();
        check("rst_op", 32'(out_op), 32'h0);
        check("rst_full", 32'(out_full), 32'h0);
        check("rst_v1", out_v1, 32'h0);
        check("rst_tag", 32'(out_rob_tag), 32'h0);
        rst = 1'b0;
        tick();

        // Ready ADD issues one edge after dispatch
        disp(6'd1, 32'd5, 4'd0, 32'd7, 4'd0, 4'd3);
        tick();
        nodisp();
        check("add_wait", 32'(out_op), 32'h0);
        tick();
        check("add_op", 32'(out_op), 32'h1);
        check("add_v1", out_v1, 32'd5);
        check("add_v2", out_v2, 32'd7);
        check("add_tag", 32'(out_rob_tag), 32'd3);
        check("add_imm", out_imm, 32'h101);
        check("add_pc", out_pc, 32'h1004);
        tick();
        check("add_nop", 32'(out_op), 32'h0);
        check("add_hold_v1", out_v1, 32'd5);

        // Wake-up through ALU CDB
        disp(6'd2, 32'd0, 4'd4, 32'd1, 4'd0, 4'd5);
        tick();
        nodisp();
        tick();
        check("wk_pre", 32'(out_op), 32'h0);
        in_alu_cdb_tag = 4'd4;
        in_alu_cdb_val = 32'h10;
        tick();
        in_alu_cdb_tag = 4'd0;
        check("wk_edge", 32'(out_op), 32'h0);
        tick();
        check("wk_op", 32'(out_op), 32'h2);
        check("wk_v1", out_v1, 32'h10);
        check("wk_tag", 32'(out_rob_tag), 32'd5);
        tick();
        check("wk_nop", 32'(out_op), 32'h0);

        // Dispatch-time bypass from LSB CDB
        disp(6'd3, 32'd2, 4'd0, 32'd0, 4'd6, 4'd7);
        in_lsb_cdb_tag = 4'd6;
        in_lsb_cdb_val = 32'hAB;
        tick();
        nodisp();
        in_lsb_cdb_tag = 4'd0;
        check("byp_wait", 32'(out_op), 32'h0);
        tick();
        check("byp_op", 32'(out_op), 32'h3);
        check("byp_v1", out_v1, 32'd2);
        check("byp_v2", out_v2, 32'hAB);
        check("byp_tag", 32'(out_rob_tag), 32'd7);

        // Fill all entries on tag 9, then drain in index order
        for (int i = 0; i < 16; i++) begin
            check("fill_full", 32'(out_full), 32'h0);
            disp(6'(i + 1), 32'd0, 4'd9, 32'(i), 4'd0, 4'(i));
            tick();
        end
        check("full_set", 32'(out_full), 32'h1);
        disp(6'h3F, 32'd1, 4'd0, 32'd1, 4'd0, 4'd1);
        tick();
        nodisp();
        check("full_ign", 32'(out_op), 32'h0);
        in_alu_cdb_tag = 4'd9;
        in_alu_cdb_val = 32'h99;
        tick();
        in_alu_cdb_tag = 4'd0;
        check("full_wake", 32'(out_op), 32'h0);
        for (int k = 0; k < 16; k++) begin
            tick();
            check("drain_op", 32'(out_op), 32'(k + 1));
            check("drain_v2", out_v2, 32'(k));
            check("drain_v1", out_v1, 32'h99);
            if (k == 0) check("full_drop", 32'(out_full), 32'h0);
        end
        tick();
        check("drain_end", 32'(out_op), 32'h0);

        // Clear overrides dispatch
        for (int i = 0; i < 5; i++) begin
            disp(6'(i + 20), 32'd0, 4'd10, 32'd0, 4'd0, 4'(i));
            tick();
        end
        disp(6'd5, 32'd1, 4'd0, 32'd1, 4'd0, 4'd1);
        in_clear = 1'b1;
        tick();
        in_clear = 1'b0;
        nodisp();
        check("clr_op", 32'(out_op), 32'h0);
        check("clr_full", 32'(out_full), 32'h0);
        tick();
        check("clr_noiss", 32'(out_op), 32'h0);
        in_alu_cdb_tag = 4'd10;
        in_alu_cdb_val = 32'h77;
        tick();
        in_alu_cdb_tag = 4'd0;
        tick();
        check("clr_nowake", 32'(out_op), 32'h0);
        tick();
        check("clr_nowake2", 32'(out_op), 32'h0);

        // Stall with rdy low
        disp(6'd8, 32'd0, 4'd12, 32'd3, 4'd0, 4'd4);
        tick();
        disp(6'd7, 32'h11, 4'd0, 32'd0, 4'd0, 4'd2);
        tick();
        disp(6'd10, 32'h22, 4'd0, 32'd0, 4'd0, 4'd6);
        tick();
        check("stl_pre", 32'(out_op), 32'h7);
        disp(6'd9, 32'h33, 4'd0, 32'd0, 4'd0, 4'd8);
        in_alu_cdb_tag = 4'd12;
        in_alu_cdb_val = 32'h55;
        in_clear = 1'b1;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stl_op", 32'(out_op), 32'h7);
            check("stl_v1", out_v1, 32'h11);
        end
        rdy = 1'b1;
        in_clear = 1'b0;
        in_alu_cdb_tag = 4'd0;
        nodisp();
        tick();
        check("res_op", 32'(out_op), 32'd10);
        check("res_v1", out_v1, 32'h22);
        tick();
        check("res_idle", 32'(out_op), 32'h0);
        in_lsb_cdb_tag = 4'd12;
        in_lsb_cdb_val = 32'h66;
        tick();
        in_lsb_cdb_tag = 4'd0;
        tick();
        check("res_b_op", 32'(out_op), 32'h8);
        check("res_b_v1", out_v1, 32'h66);
        tick();
        check("res_nod", 32'(out_op), 32'h0);

        // Asynchronous reset mid-operation
        disp(6'd11, 32'h44, 4'd0, 32'd0, 4'd0, 4'd9);
        tick();
        nodisp();
        rst = 1'b1;
        #1;
        check("arst_op", 32'(out_op), 32'h0);
        check("arst_v1", out_v1, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_drop", 32'(out_op), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_rs_scheduler.md
Name: alu_rs_scheduler

Overview:
- Reservation station and issue scheduler for the combinational ALU in the Tomasulo RISC-V core.
- Accepts decoded ALU-class instructions from the dispatcher.
- Wakes pending operands by snooping the ALU and LSB result broadcasts.
- Issues at most one ready entry per cycle, as a registered operation bundle, to the ALU inputs; flushes on ROB misprediction clear.

Parameters:
- RS_SIZE, 16, number of entries (power of two, 2..32).
- IDX_W, 4, log2(RS_SIZE).
- TAG_W, 4, ROB tag width; tag 0 means "no tag / value valid".
- OP_W, 6, inside-opcode width; op 0 is NOP.
- DATA_W, 32, operand width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rdy  in  1  global ready; low freezes all state and outputs.
- in_clear  in  1  ROB mispredict flush.
- in_disp_valid  in  1  dispatch request.
- in_disp_op  in  OP_W  opcode.
- in_disp_v1, in_disp_v2  in  DATA_W  operand values.
- in_disp_q1, in_disp_q2  in  TAG_W  operand producer tags (0 = value valid).
- in_disp_imm  in  DATA_W  immediate.
- in_disp_pc  in  DATA_W  instruction PC.
- in_disp_tag  in  TAG_W  destination ROB tag.
- in_alu_cdb_tag, in_lsb_cdb_tag  in  TAG_W  broadcast tags (0 = none).
- in_alu_cdb_val, in_lsb_cdb_val  in  DATA_W  broadcast values.
- out_full  out  1  no free entry.
- out_op  out  OP_W  issued opcode (NOP = idle).
- out_v1, out_v2, out_imm, out_pc  out  DATA_W  issued operands.
- out_rob_tag  out  TAG_W  issued destination tag.

Behaviour:
- Reset (async, rst=1): all entries invalid; out_op=NOP; all other outputs 0; out_full=0.
- rdy=0: no state or output change; dispatch, CDB inputs and clear are ignored that cycle.
- Entry fields: busy, op, v1, q1, v2, q2, imm, pc, tag.
- Ready: busy && q1==0 && q2==0, evaluated on registered state.
- Dispatch (in_disp_valid && !out_full): written to the lowest-index free entry at the edge. Per operand, if qN!=0 and qN equals a nonzero CDB tag the same cycle, store that CDB value with qN=0 (bypass). ALU CDB has priority if both tags match; tags are unique, so this cannot happen legally.
- Dispatch while out_full=1: ignored, no state change. The dispatcher must not do this.
- Wake-up: every busy entry with qN==CDB tag (nonzero) captures the value and sets qN=0 at the edge.
- Issue:
  - Each cycle, select the lowest-index ready entry; at the edge, load out_* from it and clear its busy.
  - No ready entry: out_op=NOP, other outputs keep their last values.
  - Latency: an entry woken at edge N is eligible at edge N+1, and its op is on out_op after edge N+1.
  - Dispatch with both tags 0 at edge N issues at edge N+1 at the earliest.
- Same-cycle events: an entry can be freed by issue and re-filled by dispatch at the same edge only if it is the selected free slot. The free slot is computed from pre-edge busy, so the issuing entry is not reused until the next cycle.
- out_full: combinational, high when all RS_SIZE entries are busy (pre-edge).
- in_clear=1 (rdy=1): all entries invalid and out_op=NOP at the edge. Clear overrides dispatch, wake-up and issue.
- Reset mid-operation: immediate return to the reset state; in-flight issue is dropped.

Decomposition:
- Shared constant header: NOP opcode, ZERO_TAG_ROB, ZERO_DATA, OP/TAG/DATA widths.
- Sub-module rs_prio_select: parameterised lowest-index one-hot-to-index encoder with a found flag. Instantiated twice: free-slot selection and ready-entry selection.

Test Plan:
- Reset then dispatch ADD (v1=5, v2=7, q=0, tag=3) -> next cycle out_op=ADD, out_v1=5, out_v2=7, out_rob_tag=3. Following cycle out_op=NOP.
- Dispatch with q1=4, then ALU CDB tag=4 val=0x10 two cycles later -> no issue before the broadcast; after it, out_v1=0x10 one cycle later.
- Dispatch with q2=6 in the same cycle as LSB CDB tag=6 val=0xAB -> bypass captured, entry issues next cycle with out_v2=0xAB.
- Fill 16 entries all waiting on tag 9 -> out_full=1; extra dispatch ignored. Broadcast tag 9 -> entries issue in index order 0..15, one per cycle, and out_full drops after the first issue.
- Fill 5 entries, then pulse in_clear in the same cycle as a dispatch -> all entries empty, out_op=NOP, no issue afterward.
- Hold rdy=0 for 3 cycles with a ready entry and a CDB broadcast -> outputs and state frozen; resume with rdy=1 -> issue proceeds as if no stall.
